// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for the synchronous FIFO.
// On start it drains exactly burst_len words from the FIFO read port.
// It absorbs the FIFO's one-cycle registered read latency in a 2-entry buffer.
// The words are re-emitted on a valid/ready stream, with m_last on the final word.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, burst_len    burst command, sampled only while idle
//   busy                high while a burst is in progress
//   done                one-cycle pulse after the final word transfers
//   fifo_rreq           FIFO read request (combinational)
//   fifo_empty          FIFO empty flag
//   fifo_rdata          FIFO read data, valid the cycle after a request
//   m_valid, m_data     stream word
//   m_last              marks the final word of the burst
//   m_ready             stream sink ready
module fifo_burst_reader #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LWIDTH-1:0] burst_len,
  output logic              busy,
  output logic              done,
  output logic              fifo_rreq,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_rdata,
  output logic              m_valid,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  input  logic              m_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t            state;
  logic [LWIDTH-1:0] req_left;
  logic [LWIDTH-1:0] out_left;
  logic [LWIDTH-1:0] out_left_nxt;
  logic              inflight;
  logic [WIDTH-1:0]  mem [2];
  logic              head;
  logic              tail;
  logic              head_nxt;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic [2:0]        occ_proj;
  logic              pop;
  logic              wr;
  logic              final_pop;

  // Stream handshake and buffer write strobe
  assign pop       = m_valid & m_ready;
  assign wr        = inflight;
  assign final_pop = pop && (out_left == LWIDTH'(1));

  // Occupancy the buffer will have once this cycle's write/pop land.
  // A request is only issued if its returning word will still find a free slot.
  assign occ_proj  = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_rreq = (state == READ) && (req_left != '0) && !fifo_empty
                     && (occ_proj < 3'd2);

  // Next-cycle buffer/counter view, used to register the stream outputs
  assign occ_nxt      = 2'(occ_proj);
  assign head_nxt     = head ^ pop;
  assign out_left_nxt = pop ? out_left - LWIDTH'(1) : out_left;

  // Control FSM, request/response tracking and registered stream outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_left <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_rreq;
      if (fifo_rreq) begin
        req_left <= req_left - LWIDTH'(1);
      end
      if (wr) begin
        mem[tail] <= fifo_rdata;
        tail      <= ~tail;
      end
      head     <= head_nxt;
      occ      <= occ_nxt;
      out_left <= out_left_nxt;
      m_valid  <= (occ_nxt != 2'd0);
      m_last   <= (occ_nxt != 2'd0) && (out_left_nxt == LWIDTH'(1));
      // The new head may be the word being written this cycle
      if (occ_nxt != 2'd0) begin
        m_data <= (wr && (tail == head_nxt)) ? fifo_rdata : mem[head_nxt];
      end

      case (state)
        IDLE: begin
          if (start && (burst_len != '0)) begin
            state    <= READ;
            busy     <= 1'b1;
            req_left <= burst_len;
            out_left <= burst_len;
          end
        end
        READ: begin
          if (final_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returning FIFO data must never land in a full buffer
  assert property (@(posedge clk) disable iff (reset) !(wr && (occ == 2'd2)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed self-checking bench for fifo_burst_reader.
// Contains a registered-read FIFO model feeding the DUT.
// Contains a stream monitor that records transfers, request/done counts and stall stability.
module tb_fifo_burst_reader;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LWIDTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LWIDTH-1:0] burst_len = '0;
  logic              busy;
  logic              done;
  logic              fifo_rreq;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_rdata;
  logic              m_valid;
  logic [WIDTH-1:0]  m_data;
  logic              m_last;
  logic              m_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .LWIDTH(LWIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rreq  (fifo_rreq),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  // FIFO model: one-cycle registered read, pushes happen at the falling edge
  logic [WIDTH-1:0] fmem [256];
  logic [7:0]       wptr = 8'd0;
  logic [7:0]       rptr = 8'd0;
  logic             fifo_flush = 1'b0;

  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rptr <= wptr;
    end else if (fifo_rreq && !fifo_empty) begin
      fifo_rdata <= fmem[rptr];
      rptr       <= rptr + 8'd1;
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    fmem[wptr] = d;
    wptr = wptr + 8'd1;
  endtask

  // Stream monitor, sampled mid-low-phase after the bench has driven inputs
  int               rreq_cnt = 0;
  int               done_cnt = 0;
  int               rx_n = 0;
  int               stall_err = 0;
  int               overlap_err = 0;
  logic [WIDTH-1:0] rx_data [256];
  logic             rx_last [256];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid || (m_data !== prev_data))) stall_err++;
      if (fifo_rreq) rreq_cnt++;
      if (done) done_cnt++;
      if (done && busy) overlap_err++;
      if (m_valid && m_ready) begin
        rx_data[rx_n] = m_data;
        rx_last[rx_n] = m_last;
        rx_n++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic test_reset();
    int b_rq;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, fifo_rreq, m_valid, m_last, m_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, fifo_rreq, m_valid, m_last, m_data});
    end
    reset = 1'b0;
    b_rq  = rreq_cnt;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, done, fifo_rreq, m_valid, m_last, m_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0",
               {busy, done, fifo_rreq, m_valid, m_last, m_data});
    end
    n_checks++;
    if (rreq_cnt - b_rq !== 0) begin
      n_fail++;
      $display("FAIL idle_rreq_count: got %0d expected 0", rreq_cnt - b_rq);
    end
  endtask

  task automatic test_basic();
    // Per cycle after the accepting edge (bit k = k cycles later)
    logic [7:0]       e_rreq  = 8'b0000_1111;
    logic [7:0]       e_valid = 8'b0011_1100;
    logic [7:0]       e_last  = 8'b0010_0000;
    logic [7:0]       e_busy  = 8'b0011_1111;
    logic [7:0]       e_done  = 8'b0100_0000;
    logic [WIDTH-1:0] e_data [8] = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00};
    int b_rx, b_rq, b_dn;
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    m_ready   = 1'b1;
    b_rx = rx_n; b_rq = rreq_cnt; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd4;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 8'd0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (fifo_rreq !== e_rreq[k]) begin
        n_fail++;
        $display("FAIL basic_rreq[%0d]: got %b expected %b", k, fifo_rreq, e_rreq[k]);
      end
      n_checks++;
      if (m_valid !== e_valid[k]) begin
        n_fail++;
        $display("FAIL basic_valid[%0d]: got %b expected %b", k, m_valid, e_valid[k]);
      end
      n_checks++;
      if (m_last !== e_last[k]) begin
        n_fail++;
        $display("FAIL basic_last[%0d]: got %b expected %b", k, m_last, e_last[k]);
      end
      n_checks++;
      if ({busy, done} !== {e_busy[k], e_done[k]}) begin
        n_fail++;
        $display("FAIL basic_busy_done[%0d]: got %b%b expected %b%b",
                 k, busy, done, e_busy[k], e_done[k]);
      end
      if (e_valid[k]) begin
        n_checks++;
        if (m_data !== e_data[k]) begin
          n_fail++;
          $display("FAIL basic_data[%0d]: got %h expected %h", k, m_data, e_data[k]);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if ((rx_n - b_rx) !== 4 || (rreq_cnt - b_rq) !== 4 || (done_cnt - b_dn) !== 1) begin
      n_fail++;
      $display("FAIL basic_counts: got words=%0d rreq=%0d done=%0d expected 4 4 1",
               rx_n - b_rx, rreq_cnt - b_rq, done_cnt - b_dn);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] e_data [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
    int b_rx, b_rq, b_dn, b_st;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    b_rx = rx_n; b_rq = rreq_cnt; b_dn = done_cnt; b_st = stall_err;
    start     = 1'b1;
    burst_len = 8'd4;
    for (int i = 0; i < 60; i++) begin
      m_ready = ((i % 3) == 0);
      @(negedge clk);
      start     = 1'b0;
      burst_len = 8'd0;
      if (done_cnt != b_dn) break;
    end
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ((rx_n - b_rx) !== 4 || (done_cnt - b_dn) !== 1) begin
      n_fail++;
      $display("FAIL bp_counts: got words=%0d done=%0d expected 4 1",
               rx_n - b_rx, done_cnt - b_dn);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rx_data[b_rx + i], rx_last[b_rx + i]} !== {e_data[i], (i == 3)}) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got %h last %b expected %h last %b",
                 i, rx_data[b_rx + i], rx_last[b_rx + i], e_data[i], (i == 3));
      end
    end
    n_checks++;
    if ((stall_err - b_st) !== 0 || (rreq_cnt - b_rq) !== 4) begin
      n_fail++;
      $display("FAIL bp_stall_rreq: got stall_errs=%0d rreq=%0d expected 0 4",
               stall_err - b_st, rreq_cnt - b_rq);
    end
  endtask

  task automatic test_empty_stall();
    logic [WIDTH-1:0] e_data [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    int b_rx, b_dn;
    push(8'h31); push(8'h32);
    m_ready = 1'b1;
    b_rx = rx_n; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd5;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 8'd0;
    repeat (9) @(negedge clk);
    n_checks++;
    if ({m_valid, busy, fifo_rreq} !== 3'b010 || (rx_n - b_rx) !== 2) begin
      n_fail++;
      $display("FAIL empty_stall: got valid=%b busy=%b rreq=%b words=%0d expected 0 1 0 2",
               m_valid, busy, fifo_rreq, rx_n - b_rx);
    end
    push(8'h33); push(8'h34); push(8'h35);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_cnt != b_dn) break;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ((rx_n - b_rx) !== 5 || (done_cnt - b_dn) !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_counts: got words=%0d done=%0d busy=%b expected 5 1 0",
               rx_n - b_rx, done_cnt - b_dn, busy);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rx_data[b_rx + i], rx_last[b_rx + i]} !== {e_data[i], (i == 4)}) begin
        n_fail++;
        $display("FAIL empty_word[%0d]: got %h last %b expected %h last %b",
                 i, rx_data[b_rx + i], rx_last[b_rx + i], e_data[i], (i == 4));
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    logic [WIDTH-1:0] e_data [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    int b_rx, b_rq, b_dn;
    m_ready = 1'b1;
    b_rq = rreq_cnt; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ((rreq_cnt - b_rq) !== 0 || (done_cnt - b_dn) !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got rreq=%0d done=%0d busy=%b expected 0 0 0",
               rreq_cnt - b_rq, done_cnt - b_dn, busy);
    end
    push(8'h41); push(8'h42); push(8'h43); push(8'h44); push(8'h45); push(8'h46);
    b_rx = rx_n; b_rq = rreq_cnt; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    burst_len = 8'd2;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_cnt != b_dn) break;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ((rx_n - b_rx) !== 4 || (done_cnt - b_dn) !== 1 || (rreq_cnt - b_rq) !== 4) begin
      n_fail++;
      $display("FAIL ignore_counts: got words=%0d done=%0d rreq=%0d expected 4 1 4",
               rx_n - b_rx, done_cnt - b_dn, rreq_cnt - b_rq);
    end
    n_checks++;
    if (8'(wptr - rptr) !== 8'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_residual: got fifo_words=%0d busy=%b expected 2 0",
               8'(wptr - rptr), busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rx_data[b_rx + i], rx_last[b_rx + i]} !== {e_data[i], (i == 3)}) begin
        n_fail++;
        $display("FAIL ignore_word[%0d]: got %h last %b expected %h last %b",
                 i, rx_data[b_rx + i], rx_last[b_rx + i], e_data[i], (i == 3));
      end
    end
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Words 0x51..0x54 are consumed by the aborted burst (two delivered, two dropped)
    logic [WIDTH-1:0] e_data [3] = '{8'h55, 8'h56, 8'h57};
    int b_rx, b_dn;
    for (int i = 0; i < 11; i++) push(8'(8'h51 + i));
    m_ready = 1'b1;
    b_rx = rx_n; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd8;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if ((rx_n - b_rx) >= 2) break;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, fifo_rreq, m_valid, m_last, m_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {busy, done, fifo_rreq, m_valid, m_last, m_data});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ((rx_n - b_rx) !== 2 || (done_cnt - b_dn) !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got words=%0d done=%0d busy=%b expected 2 0 0",
               rx_n - b_rx, done_cnt - b_dn, busy);
    end
    b_rx = rx_n; b_dn = done_cnt;
    start     = 1'b1;
    burst_len = 8'd3;
    @(negedge clk);
    start     = 1'b0;
    burst_len = 8'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_cnt != b_dn) break;
    end
    @(negedge clk);
    n_checks++;
    if ((rx_n - b_rx) !== 3 || (done_cnt - b_dn) !== 1) begin
      n_fail++;
      $display("FAIL restart_counts: got words=%0d done=%0d expected 3 1",
               rx_n - b_rx, done_cnt - b_dn);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rx_data[b_rx + i], rx_last[b_rx + i]} !== {e_data[i], (i == 2)}) begin
        n_fail++;
        $display("FAIL restart_word[%0d]: got %h last %b expected %h last %b",
                 i, rx_data[b_rx + i], rx_last[b_rx + i], e_data[i], (i == 2));
      end
    end
    n_checks++;
    if (overlap_err !== 0 || stall_err !== 0) begin
      n_fail++;
      $display("FAIL global_protocol: got done_while_busy=%0d stall_errs=%0d expected 0 0",
               overlap_err, stall_err);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_and_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever wedges
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
